sram_port_arbiter: RTL

Shares one single-port SRAM port (the query-patch, leaf or best-array port-0 style interface: active-low `csb0`/`web0`, one address, one write word, one read word) between the Wishbone slave controller and the accelerator engines. It grants one requester per cycle, drives the memory control signals, and routes returned read data back to the owner after the fixed SRAM read latency. When `debug_i` is set, Wishbone gets strict priority. Otherwise it uses round-robin with optional bounded burst locking.

---
 rtl/fann_pkg.sv | 6 +
 rtl/rd_return_pipe.sv | 37 +++
 rtl/sram_port_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fann_pkg.sv
// fann_pkg: requester indices and lock-state encoding shared by the SRAM port arbiter.
package fann_pkg;
    localparam int REQ_WBS = 0;
    localparam int REQ_ACC = 1;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_st_e;
endpackage

// File: rtl/rd_return_pipe.sv
// rd_return_pipe: carries {valid, owner} of issued reads across the SRAM latency
// and registers the returned word together with a one-hot valid for its owner.
module rd_return_pipe #(
    parameter int RD_LAT  = 1,
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int IW      = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               issue,
    input  logic [IW-1:0]      owner,
    input  logic [DATA_W-1:0]  rdata0_i,
    output logic [NUM_REQ-1:0] rvalid_o,
    output logic [DATA_W-1:0]  rdata_o
);
    logic [RD_LAT-1:0]         vld_q;
    logic [RD_LAT-1:0][IW-1:0] own_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            vld_q    <= '0;
            own_q    <= '0;
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            vld_q[0] <= issue;
            own_q[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
            rvalid_o <= vld_q[RD_LAT-1] ? NUM_REQ'(1) << own_q[RD_LAT-1] : '0;
            if (vld_q[RD_LAT-1]) rdata_o <= rdata0_i;
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between Wishbone and the engines
// with debug priority, bounded burst locking and round-robin fallback.
module sram_port_arbiter
    import fann_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 64,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      debug_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      csb0_o,
    output logic                      web0_o,
    output logic [ADDR_W-1:0]         addr0_o,
    output logic [DATA_W-1:0]         wdata0_o,
    input  logic [DATA_W-1:0]         rdata0_i
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    lock_st_e      st_q, st_d;
    logic [IW-1:0] rr_q, rr_d, own_q, own_d, gidx, cand;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gv, lock_ok;

    // An engine's lock is void while debug is up; a Wishbone lock survives it.
    assign lock_ok = st_q == LOCKED && req_i[own_q] && cnt_q < CW'(MAX_LOCK) &&
                     !(debug_i && own_q != IW'(REQ_WBS));

    always_comb begin
        gv   = 1'b0;
        gidx = '0;
        cand = '0;
        if (debug_i && req_i[REQ_WBS]) begin
            gv   = 1'b1;
            gidx = IW'(REQ_WBS);
        end else if (lock_ok) begin
            gv   = 1'b1;
            gidx = own_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = IW'((int'(rr_q) + k) % NUM_REQ);
                if (req_i[cand]) begin
                    gv   = 1'b1;
                    gidx = cand;
                end
            end
        end
    end

    assign gnt_o    = gv ? NUM_REQ'(1) << gidx : '0;
    assign csb0_o   = !gv;
    assign web0_o   = !(gv && we_i[gidx]);
    assign addr0_o  = gv ? addr_i[int'(gidx)*ADDR_W +: ADDR_W] : '0;
    assign wdata0_o = gv ? wdata_i[int'(gidx)*DATA_W +: DATA_W] : '0;
    assign rr_d     = gv ? IW'((int'(gidx) + 1) % NUM_REQ) : rr_q;

    // Reaching MAX_LOCK always falls back to UNLOCKED, so the owner cannot relock that cycle.
    always_comb begin
        st_d  = st_q;
        own_d = own_q;
        cnt_d = cnt_q;
        if (st_q == UNLOCKED) begin
            if (gv && lock_i[gidx] && !(debug_i && gidx != IW'(REQ_WBS))) begin
                st_d  = LOCKED;
                own_d = gidx;
                cnt_d = CW'(1);
            end
        end else if (lock_ok && lock_i[own_q]) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            st_d = UNLOCKED;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            st_q  <= UNLOCKED;
            own_q <= '0;
            cnt_q <= '0;
            rr_q  <= '0;
        end else begin
            st_q  <= st_d;
            own_q <= own_d;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end

    rd_return_pipe #(
        .RD_LAT (RD_LAT),
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_rd_return_pipe (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .issue     (gv && !we_i[gidx]),
        .owner     (gidx),
        .rdata0_i  (rdata0_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o)
    );
endmodule
